ysyx_23060240_lsu_axi_rd_master: RTL and testbench

//   AXI4-Lite read initiator inside the LSU. Takes one load request at a time from
//   the EXU/LSU stage, issues one AR beat, and accepts one R beat from the data-SRAM

---
 rtl/ysyx_23060240_lsu_pkg.sv | 30 +++
 rtl/ysyx_23060240_load_extend.sv | 28 ++
 rtl/ysyx_23060240_lsu_axi_rd_master.sv | 126 ++++++++++++
 tb/tb_ysyx_23060240_lsu_axi_rd_master.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060240_lsu_pkg.sv
// Shared definitions for the LSU load path: funct3 codes, FSM encoding, AXI response codes.
package ysyx_23060240_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_AR   = 2'b01,
        ST_R    = 2'b10,
        ST_RESP = 2'b11
    } lsu_rd_state_t;

    // Only the explicitly sized loads can be misaligned; byte loads never are.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if ((funct3 == F3_LH || funct3 == F3_LHU) && off[0])
            mis = 1'b1;
        if (funct3 == F3_LW && off != 2'b00)
            mis = 1'b1;
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_23060240_load_extend.sv
// Picks the addressed byte/half/word out of a 32-bit read beat and sign/zero-extends it.
module ysyx_23060240_load_extend
    import ysyx_23060240_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        off,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = rdata[{off[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'h000000, byte_sel};
            F3_LHU:  data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_23060240_lsu_axi_rd_master.sv
// Single-outstanding AXI4-Lite read initiator for LSU loads.
//   state   | meaning
//   IDLE    | waiting for a load request (req_ready high)
//   AR      | address beat presented, waiting for arready
//   R       | rready high, waiting for the read data beat
//   RESP    | result presented to the consumer, waiting for resp_ready
module ysyx_23060240_lsu_axi_rd_master
    import ysyx_23060240_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp
);

    lsu_rd_state_t     state, state_d;
    logic [1:0]        off, off_d;
    logic [2:0]        funct3, funct3_d;
    logic [ADDR_W-1:0] araddr_d;
    logic              arvalid_d, rready_d, resp_valid_d, resp_err_d;
    logic [DATA_W-1:0] resp_data_d, ext_data;

    ysyx_23060240_load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .rdata  (m_rdata),
        .off    (off),
        .funct3 (funct3),
        .data   (ext_data)
    );

    // Gated by rst so nothing is accepted while reset is held.
    assign req_ready = rst && (state == ST_IDLE);

    always_comb begin
        state_d      = state;
        off_d        = off;
        funct3_d     = funct3;
        araddr_d     = m_araddr;
        arvalid_d    = m_arvalid;
        rready_d     = m_rready;
        resp_valid_d = resp_valid;
        resp_data_d  = resp_data;
        resp_err_d   = resp_err;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    off_d    = req_addr[1:0];
                    funct3_d = req_funct3;
                    araddr_d = {req_addr[ADDR_W-1:2], 2'b00};
                    if (is_misaligned(req_funct3, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = '0;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d   = ST_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_AR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (m_rvalid) begin
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = ext_data;
                    resp_err_d   = (m_rresp != AXI_RESP_OKAY);
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            off        <= 2'b00;
            funct3     <= 3'b000;
            m_araddr   <= '0;
            m_arvalid  <= 1'b0;
            m_rready   <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_d;
            off        <= off_d;
            funct3     <= funct3_d;
            m_araddr   <= araddr_d;
            m_arvalid  <= arvalid_d;
            m_rready   <= rready_d;
            resp_valid <= resp_valid_d;
            resp_data  <= resp_data_d;
            resp_err   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_lsu_axi_rd_master.sv
// Directed bench for the LSU AXI4-Lite read master: loads, extension, misalignment, stalls, reset.
module tb_ysyx_23060240_lsu_axi_rd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_data;
    logic [31:0] m_araddr;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;

    int tests = 0;
    int fails = 0;
    int ar_cnt = 0;
    int r_cnt = 0;
    int arv_cycles = 0;
    logic [31:0] last_araddr = 32'h0;

    ysyx_23060240_lsu_axi_rd_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .m_araddr   (m_araddr),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .m_rdata    (m_rdata),
        .m_rresp    (m_rresp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_arvalid) arv_cycles++;
        if (m_arvalid && m_arready) begin
            ar_cnt++;
            last_araddr = m_araddr;
        end
        if (m_rvalid && m_rready) r_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one load (responder state preset by caller), waits for resp_valid, then consumes it.
    task automatic run_load(input logic [31:0] a, input logic [2:0] f3,
                            output logic [31:0] d, output logic e, output int lat);
        req_addr   = a;
        req_funct3 = f3;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            tick();
            lat++;
        end
        tests++;
        if (!resp_valid) begin
            fails++;
            $display("FAIL resp_timeout: resp_valid=%0b after %0d cycles, required 1", resp_valid, lat);
        end
        d = resp_data;
        e = resp_err;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({m_arvalid, m_rready, resp_valid, resp_err, req_ready} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: arvalid,rready,resp_valid,err,req_ready=%05b required 00000",
                     {m_arvalid, m_rready, resp_valid, resp_err, req_ready});
        end
        tests++;
        if (m_araddr !== 32'h0 || resp_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: araddr=%h resp_data=%h required 0/0", m_araddr, resp_data);
        end
        rst = 1'b1;
        tick();
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: req_ready=%0b required 1", req_ready);
        end
    endtask

    task automatic test_lw_basic();
        logic [31:0] d;
        logic e;
        int lat;
        m_rdata = 32'hDEADBEEF;
        m_rresp = 2'b00;
        run_load(32'h80000004, 3'b010, d, e, lat);
        tests++;
        if (last_araddr !== 32'h80000004) begin
            fails++;
            $display("FAIL lw_araddr: got %h required 80000004", last_araddr);
        end
        tests++;
        if (d !== 32'hDEADBEEF || e !== 1'b0) begin
            fails++;
            $display("FAIL lw_data: got %h err=%0b required deadbeef err=0", d, e);
        end
        tests++;
        if (lat != 3) begin
            fails++;
            $display("FAIL lw_latency: got %0d required 3", lat);
        end
        tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL lw_return_idle: resp_valid=%0b req_ready=%0b required 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_extend();
        logic [31:0] d;
        logic e;
        int lat;
        m_rdata = 32'h80FF1234;
        run_load(32'h80000003, 3'b000, d, e, lat);
        tests++;
        if (last_araddr !== 32'h80000000) begin
            fails++;
            $display("FAIL lb_araddr: got %h required 80000000", last_araddr);
        end
        tests++;
        if (d !== 32'hFFFFFF80) begin
            fails++;
            $display("FAIL lb_data: got %h required ffffff80", d);
        end
        run_load(32'h80000003, 3'b100, d, e, lat);
        tests++;
        if (d !== 32'h00000080) begin
            fails++;
            $display("FAIL lbu_data: got %h required 00000080", d);
        end
        m_rdata = 32'h8001ABCD;
        run_load(32'h80000002, 3'b001, d, e, lat);
        tests++;
        if (d !== 32'hFFFF8001) begin
            fails++;
            $display("FAIL lh_data: got %h required ffff8001", d);
        end
        run_load(32'h80000002, 3'b101, d, e, lat);
        tests++;
        if (d !== 32'h00008001) begin
            fails++;
            $display("FAIL lhu_data: got %h required 00008001", d);
        end
        run_load(32'h80000000, 3'b001, d, e, lat);
        tests++;
        if (d !== 32'hFFFFABCD) begin
            fails++;
            $display("FAIL lh_low_data: got %h required ffffabcd", d);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] d;
        logic e;
        int lat;
        int arv0;
        arv0 = arv_cycles;
        m_rdata = 32'h12345678;
        run_load(32'h80000002, 3'b010, d, e, lat);
        tests++;
        if (d !== 32'h0 || e !== 1'b1) begin
            fails++;
            $display("FAIL mis_lw_resp: data=%h err=%0b required 0/1", d, e);
        end
        tests++;
        if (lat != 1) begin
            fails++;
            $display("FAIL mis_lw_latency: got %0d required 1", lat);
        end
        run_load(32'h80000001, 3'b101, d, e, lat);
        tests++;
        if (d !== 32'h0 || e !== 1'b1 || lat != 1) begin
            fails++;
            $display("FAIL mis_lhu_resp: data=%h err=%0b lat=%0d required 0/1/1", d, e, lat);
        end
        tests++;
        if (arv_cycles != arv0) begin
            fails++;
            $display("FAIL mis_no_arvalid: arvalid cycles=%0d required %0d", arv_cycles, arv0);
        end
    endtask

    task automatic test_stalls();
        int ar0, r0;
        logic ok;
        logic [31:0] held;
        ar0 = ar_cnt;
        r0  = r_cnt;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = 32'h12345678;
        m_rresp   = 2'b00;
        req_addr   = 32'h80000012;
        req_funct3 = 3'b000;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        req_addr  = 32'h0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (m_arvalid !== 1'b1 || m_araddr !== 32'h80000010 || req_ready !== 1'b0) ok = 1'b0;
            tick();
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_ar_hold: arvalid=%0b araddr=%h req_ready=%0b required 1/80000010/0",
                     m_arvalid, m_araddr, req_ready);
        end
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        tests++;
        if (m_arvalid !== 1'b0 || m_rready !== 1'b1) begin
            fails++;
            $display("FAIL stall_ar_done: arvalid=%0b rready=%0b required 0/1", m_arvalid, m_rready);
        end
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (m_rready !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 1'b0) ok = 1'b0;
            tick();
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_r_wait: rready=%0b resp_valid=%0b req_ready=%0b required 1/0/0",
                     m_rready, resp_valid, req_ready);
        end
        m_rvalid = 1'b1;
        tick();
        m_rvalid = 1'b0;
        m_rdata  = 32'hA5A5A5A5;
        held = resp_data;
        tests++;
        if (resp_valid !== 1'b1 || held !== 32'h00000034) begin
            fails++;
            $display("FAIL stall_resp: resp_valid=%0b data=%h required 1/00000034", resp_valid, held);
        end
        ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (resp_valid !== 1'b1 || resp_data !== 32'h00000034 || req_ready !== 1'b0 || m_rready !== 1'b0)
                ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_resp_hold: resp_valid=%0b data=%h req_ready=%0b required 1/00000034/0",
                     resp_valid, resp_data, req_ready);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release: resp_valid=%0b req_ready=%0b required 0/1", resp_valid, req_ready);
        end
        tests++;
        if (ar_cnt - ar0 != 1 || r_cnt - r0 != 1) begin
            fails++;
            $display("FAIL stall_handshakes: ar=%0d r=%0d required 1/1", ar_cnt - ar0, r_cnt - r0);
        end
        m_arready = 1'b1;
        m_rvalid  = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic e;
        int lat;
        logic ok;
        m_arready = 1'b1;
        m_rvalid  = 1'b0;
        req_addr   = 32'h80000020;
        req_funct3 = 3'b010;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tests++;
        if (m_rready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_in_r: rready=%0b required 1", m_rready);
        end
        rst = 1'b0;
        #1;
        tests++;
        if ({m_arvalid, m_rready, resp_valid, resp_err, req_ready} !== 5'b0 || m_araddr !== 32'h0
            || resp_data !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_outputs: ctrl=%05b araddr=%h data=%h required 00000/0/0",
                     {m_arvalid, m_rready, resp_valid, resp_err, req_ready}, m_araddr, resp_data);
        end
        tick();
        tick();
        rst = 1'b1;
        m_rvalid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (resp_valid !== 1'b0 || m_rready !== 1'b0 || req_ready !== 1'b1) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rstmid_idle: resp_valid=%0b rready=%0b req_ready=%0b required 0/0/1",
                     resp_valid, m_rready, req_ready);
        end
        m_rdata = 32'h11223344;
        m_rresp = 2'b10;
        run_load(32'h80000024, 3'b010, d, e, lat);
        tests++;
        if (e !== 1'b1 || d !== 32'h11223344) begin
            fails++;
            $display("FAIL slverr: err=%0b data=%h required 1/11223344", e, d);
        end
        m_rresp = 2'b00;
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_funct3 = 3'b0;
        resp_ready = 1'b0;
        m_arready  = 1'b1;
        m_rvalid   = 1'b1;
        m_rdata    = 32'h0;
        m_rresp    = 2'b00;
        tick();
        tick();
        test_reset();
        test_lw_basic();
        test_extend();
        test_misaligned();
        test_stalls();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
